// File: rtl/oric_video_gen_pkg.sv
// rtl/oric_video_gen_pkg.sv - shared state encoding and timing constants for the Oric video source
package oric_video_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_HSYNC,
    ST_ACTIVE
  } vid_state_e;

  localparam int HALF_LINE     = 192;
  localparam int CLKS_PAIR_DEF = 9;

  // Strobe phases within one 9-CLK pixel pair: 4 CLKs then 5 CLKs
  localparam logic [3:0] PHASE_A = 4'd0;
  localparam logic [3:0] PHASE_B = 4'd4;

endpackage

// File: rtl/oric_pix_strobe.sv
// rtl/oric_pix_strobe.sv - pixel phase counter producing strobes alternately 4 and 5 CLKs apart
module oric_pix_strobe
  import oric_video_gen_pkg::*;
#(
  parameter int CLKS_PAIR = CLKS_PAIR_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ps_o
);

  logic [3:0] phase_q;
  logic [3:0] phase_d;

  always_comb begin
    phase_d = (phase_q == 4'(CLKS_PAIR - 1)) ? 4'd0 : phase_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 4'd0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign ps_o = (phase_q == PHASE_A) || (phase_q == PHASE_B);

endmodule

// File: rtl/oric_video_gen.sv
// rtl/oric_video_gen.sv - Oric-style RGB+SYNC field generator with one-pixel-ahead pixel fetch
module oric_video_gen
  import oric_video_gen_pkg::*;
#(
  parameter int CLKS_PAIR   = CLKS_PAIR_DEF,
  parameter int H_SYNC      = 24,
  parameter int H_ACTIVE    = 360,
  parameter int V_SYNC_HALF = 7,
  parameter int V_LINES     = 309
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       EN,
  output logic       PIX_REQ,
  output logic [8:0] PIX_X,
  output logic [8:0] PIX_Y,
  input  logic [2:0] RGB_IN,
  output logic       RED,
  output logic       GREEN,
  output logic       BLUE,
  output logic       SYNC,
  output logic       FIELD_START
);

  localparam logic [10:0] VS_LAST     = 11'(V_SYNC_HALF * HALF_LINE - 1);
  localparam logic [8:0]  H_SYNC_LAST = 9'(H_SYNC - 1);
  localparam logic [8:0]  H_LAST      = 9'(H_SYNC + H_ACTIVE - 1);
  localparam logic [8:0]  V_LAST      = 9'(V_LINES - 1);
  // hcnt values whose following pixel lies in [last hsync pixel, second-to-last active pixel]
  localparam logic [8:0]  REQ_FIRST   = 9'(H_SYNC - 2);
  localparam logic [8:0]  REQ_LAST    = 9'(H_SYNC + H_ACTIVE - 3);

  logic ps;

  oric_pix_strobe #(
    .CLKS_PAIR(CLKS_PAIR)
  ) u_pix_strobe (
    .clk_i (CLK),
    .rst_ni(NRST),
    .ps_o  (ps)
  );

  vid_state_e  state_q;
  logic [10:0] vcnt_q;
  logic [8:0]  hcnt_q;
  logic [8:0]  line_q;
  logic        sync_q;
  logic [2:0]  rgb_q;
  logic        req_q;
  logic [8:0]  pix_x_q;
  logic [8:0]  pix_y_q;
  logic        fs_q;
  logic        req_d1_q;
  logic        req_d2_q;
  logic [2:0]  fetch_q;

  logic field_end;
  logic start_vsync;
  logic req_fire;

  assign field_end   = (state_q == ST_ACTIVE) && (hcnt_q == H_LAST) && (line_q == V_LAST);
  assign start_vsync = EN && ((state_q == ST_IDLE) || field_end);
  assign req_fire    = ((state_q == ST_HSYNC) || (state_q == ST_ACTIVE)) &&
                       (hcnt_q >= REQ_FIRST) && (hcnt_q <= REQ_LAST);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
      vcnt_q  <= '0;
      hcnt_q  <= '0;
      line_q  <= '0;
      sync_q  <= 1'b1;
      rgb_q   <= '0;
      req_q   <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      fs_q    <= 1'b0;
    end else begin
      req_q <= 1'b0;
      fs_q  <= 1'b0;
      if (ps) begin
        if (start_vsync) begin
          state_q <= ST_VSYNC;
          vcnt_q  <= '0;
          hcnt_q  <= '0;
          line_q  <= '0;
          sync_q  <= 1'b0;
          rgb_q   <= '0;
          fs_q    <= 1'b1;
        end else begin
          case (state_q)
            ST_IDLE: begin
              sync_q <= 1'b1;
              rgb_q  <= '0;
            end
            ST_VSYNC: begin
              if (vcnt_q == VS_LAST) begin
                state_q <= ST_HSYNC;
                hcnt_q  <= '0;
                line_q  <= '0;
              end else begin
                vcnt_q <= vcnt_q + 11'd1;
              end
            end
            ST_HSYNC: begin
              hcnt_q <= hcnt_q + 9'd1;
              if (hcnt_q == H_SYNC_LAST) begin
                state_q <= ST_ACTIVE;
                sync_q  <= 1'b1;
                rgb_q   <= fetch_q;
              end
            end
            ST_ACTIVE: begin
              if (hcnt_q == H_LAST) begin
                hcnt_q <= '0;
                rgb_q  <= '0;
                if (line_q == V_LAST) begin
                  // EN was low at the field boundary: park with SYNC high
                  state_q <= ST_IDLE;
                  line_q  <= '0;
                end else begin
                  state_q <= ST_HSYNC;
                  line_q  <= line_q + 9'd1;
                  sync_q  <= 1'b0;
                end
              end else begin
                hcnt_q <= hcnt_q + 9'd1;
                rgb_q  <= fetch_q;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        if (req_fire) begin
          req_q   <= 1'b1;
          pix_x_q <= hcnt_q - REQ_FIRST;
          pix_y_q <= line_q;
        end
      end
    end
  end

  // Return data is captured on the third CLK after the request; the next strobe is always later
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      req_d1_q <= 1'b0;
      req_d2_q <= 1'b0;
      fetch_q  <= '0;
    end else begin
      req_d1_q <= req_q;
      req_d2_q <= req_d1_q;
      if (req_d2_q) begin
        fetch_q <= RGB_IN;
      end
    end
  end

  assign PIX_REQ     = req_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign RED         = rgb_q[2];
  assign GREEN       = rgb_q[1];
  assign BLUE        = rgb_q[0];
  assign SYNC        = sync_q;
  assign FIELD_START = fs_q;

endmodule

// File: tb/tb_oric_video_gen.sv
// tb/tb_oric_video_gen.sv - self-checking bench for oric_video_gen with a pixel-index field model
module tb_oric_video_gen;

  localparam int NLINES    = 4;
  localparam int VS_PIX    = 1344;
  localparam int LINE_PIX  = 384;
  localparam int FIELD_PIX = VS_PIX + NLINES * LINE_PIX;

  logic       CLK;
  logic       NRST;
  logic       EN;
  logic [2:0] RGB_IN;
  logic       PIX_REQ;
  logic [8:0] PIX_X;
  logic [8:0] PIX_Y;
  logic       RED;
  logic       GREEN;
  logic       BLUE;
  logic       SYNC;
  logic       FIELD_START;

  oric_video_gen #(
    .V_LINES(NLINES)
  ) u_dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .EN         (EN),
    .PIX_REQ    (PIX_REQ),
    .PIX_X      (PIX_X),
    .PIX_Y      (PIX_Y),
    .RGB_IN     (RGB_IN),
    .RED        (RED),
    .GREEN      (GREEN),
    .BLUE       (BLUE),
    .SYNC       (SYNC),
    .FIELD_START(FIELD_START)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  int fs_cyc = 0, fs_period = 0, fs_count = 0;
  int req_cnt = 0, field_reqs = 0;
  int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  int fall_cyc = 0, vs_len = 0, hs_len = 0, line_period = 0;
  bit fall_vs = 1'b0, prev_fall_hs = 1'b0, sync_prev = 1'b1;

  function automatic logic [2:0] pix_fn(input int x, input int y);
    return 3'((x + 3 * y) & 7);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      if (n_total - n_pass >= 40) begin
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  endtask

  task automatic wait_fs(input int bound, output bit found, output int lat);
    found = 1'b0;
    lat = 0;
    while (!found && lat < bound) begin
      @(posedge CLK);
      #2;
      lat++;
      if (FIELD_START) found = 1'b1;
    end
  endtask

  // Pixel source: data valid only in the CLK just before the 3rd edge after PIX_REQ
  initial begin : src
    bit r0, r1, r2;
    logic [2:0] v0, v1, v2;
    r0 = 0; r1 = 0; r2 = 0;
    v0 = 0; v1 = 0; v2 = 0;
    RGB_IN = 3'd0;
    forever begin
      @(posedge CLK);
      #1;
      r2 = r1; v2 = v1;
      r1 = r0; v1 = v0;
      r0 = PIX_REQ;
      v0 = pix_fn(int'(PIX_X), int'(PIX_Y));
      RGB_IN = r2 ? v2 : 3'($urandom);
    end
  end

  // Model: each strobe advances a pixel index through the field; outputs follow from the index
  initial begin : cmp
    int n, p, q, ln, h, ex, ey;
    bit in_f, e_sync, e_req, e_fs;
    logic [2:0] e_rgb;
    n = 0; p = 0; in_f = 0;
    e_sync = 1; e_rgb = 0; e_req = 0; e_fs = 0; ex = 0; ey = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (!NRST) begin
        n = 0; in_f = 0; p = 0;
        e_sync = 1; e_rgb = 0; e_req = 0; e_fs = 0;
        sync_prev = 1'b1;
      end else begin
        e_req = 0;
        e_fs = 0;
        if ((n % 9 == 0) || (n % 9 == 4)) begin
          if (!in_f) begin
            if (EN) begin in_f = 1; p = 0; e_fs = 1; end
          end else if (p == FIELD_PIX - 1) begin
            if (EN) begin p = 0; e_fs = 1; end
            else in_f = 0;
          end else begin
            p++;
          end
          if (!in_f || p < VS_PIX) begin
            e_sync = !in_f;
            e_rgb = 0;
          end else begin
            q = p - VS_PIX;
            ln = q / LINE_PIX;
            h = q % LINE_PIX;
            e_sync = (h >= 24);
            e_rgb = (h >= 24) ? pix_fn(h - 24, ln) : 3'd0;
            if (h >= 23 && h < 23 + 360) begin
              e_req = 1; ex = h - 23; ey = ln;
            end
          end
        end
        n++;
      end
      check("SYNC", int'(SYNC), int'(e_sync));
      check("RGB", int'({RED, GREEN, BLUE}), int'(e_rgb));
      check("PIX_REQ", int'(PIX_REQ), int'(e_req));
      check("FIELD_START", int'(FIELD_START), int'(e_fs));
      if (e_req) begin
        check("PIX_X", int'(PIX_X), ex);
        check("PIX_Y", int'(PIX_Y), ey);
      end
      if (NRST) begin
        if (FIELD_START) begin
          fs_period = cyc - fs_cyc;
          fs_cyc = cyc;
          fs_count++;
          field_reqs = req_cnt;
          req_cnt = 0;
        end
        if (PIX_REQ) begin
          if (req_cnt == 0) begin first_x = int'(PIX_X); first_y = int'(PIX_Y); end
          last_x = int'(PIX_X);
          last_y = int'(PIX_Y);
          req_cnt++;
        end
        if (!SYNC && sync_prev) begin
          if (!FIELD_START && prev_fall_hs) line_period = cyc - fall_cyc;
          prev_fall_hs = !FIELD_START;
          fall_vs = FIELD_START;
          fall_cyc = cyc;
        end
        if (SYNC && !sync_prev) begin
          if (fall_vs) vs_len = cyc - fall_cyc;
          else hs_len = cyc - fall_cyc;
        end
        sync_prev = SYNC;
      end
    end
  end

  initial begin : stim
    bit got;
    int lat, fs_before;
    NRST = 1'b0;
    EN = 1'b0;
    repeat (3) @(negedge CLK);
    NRST = 1'b1;
    repeat (20) @(negedge CLK);
    EN = 1'b1;
    wait_fs(12, got, lat);
    check("fs_after_en_found", int'(got), 1);

    // Reset while in active video of line 0
    repeat (7000) @(negedge CLK);
    #1 NRST = 1'b0;
    #1;
    check("rst_SYNC", int'(SYNC), 1);
    check("rst_RGB", int'({RED, GREEN, BLUE}), 0);
    check("rst_PIX_REQ", int'(PIX_REQ), 0);
    check("rst_FIELD_START", int'(FIELD_START), 0);
    check("rst_PIX_X", int'(PIX_X), 0);
    check("rst_PIX_Y", int'(PIX_Y), 0);
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    @(posedge CLK);
    #2;
    check("fs_first_ps_after_reset", int'(FIELD_START), 1);

    wait_fs(13000, got, lat);
    check("fs_second_found", int'(got), 1);
    check("field_period_clks", fs_period, 12960);
    check("reqs_per_field", field_reqs, 1440);
    check("first_req_x", first_x, 0);
    check("first_req_y", first_y, 0);
    check("last_req_x", last_x, 359);
    check("last_req_y", last_y, 3);
    // vsync (6048) merges with line 0 hsync (108)
    check("field_sync_low_clks", vs_len, 6156);
    check("hsync_low_clks", hs_len, 108);
    check("line_period_clks", line_period, 1728);

    // Drop EN during line 1: field must still run to its last line
    repeat (8100) @(negedge CLK);
    EN = 1'b0;
    repeat (12960 - 8100 + 100) @(negedge CLK);
    check("reqs_after_en_drop", req_cnt, 1440);
    check("last_req_x_after_drop", last_x, 359);
    check("last_req_y_after_drop", last_y, 3);
    check("idle_SYNC", int'(SYNC), 1);
    fs_before = fs_count;
    repeat (2000) @(negedge CLK);
    check("idle_no_field_start", fs_count, fs_before);
    check("idle_no_req", req_cnt, 1440);

    EN = 1'b1;
    wait_fs(6, got, lat);
    check("fs_after_reenable", int'(got), 1);
    repeat (100) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
